// File: rtl/instruction_encoder.sv
// rtl/instruction_encoder.sv - packs RV32 R/I/S/B fields into words and streams them to instruction memory
// Optional immediate range checker: define ENC_RANGE_CHECK_EN to build it (otherwise imm_err is tied low).
module instruction_encoder #(
    parameter int N         = 32,
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              finish,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [6:0]        opcode,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    input  logic [N-1:0]      imm,
    output logic              mem_we,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [N-1:0]      mem_wdata,
    output logic              done,
    output logic              imm_err,
    output logic [ADDR_W:0]   word_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE
    } state_t;

    localparam logic [6:0]        OP_R      = 7'b0110011;
    localparam logic [6:0]        OP_S      = 7'b0100011;
    localparam logic [6:0]        OP_B      = 7'b1100011;
    localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] next_addr;
    logic              addr_full;
    logic              finish_pend;
    logic              drained;
    logic              wr_acc;
    logic              last_wr;
    logic              hs;
    logic [N-1:0]      enc_word;

    assign wr_acc  = mem_we && mem_ready;
    assign drained = !mem_we || mem_ready;
    assign last_wr = wr_acc && (mem_addr == LAST_ADDR);

    // A finish seen while a write is stalled is remembered until the write drains;
    // once the top address has been loaded nothing more can be accepted.
    assign in_ready = (state == LOAD) && drained && !finish && !finish_pend && !addr_full;
    assign hs       = in_valid && in_ready && !start;
    assign done     = (state == DONE);

    always_comb begin
        enc_word = '0;
        case (opcode)
            OP_R:    enc_word = {funct7, rs2, rs1, funct3, rd, opcode};
            OP_S:    enc_word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            OP_B:    enc_word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
            default: enc_word = {imm[11:0], rs1, funct3, rd, opcode};
        endcase
    end

`ifdef ENC_RANGE_CHECK_EN
    logic fits12;
    logic fits13;
    logic range_bad;
    logic imm_err_q;

    // Sign-extension check: every bit above the field's sign bit must match it.
    assign fits12 = (&imm[N-1:11]) || (~|imm[N-1:11]);
    assign fits13 = (&imm[N-1:12]) || (~|imm[N-1:12]);

    always_comb begin
        range_bad = 1'b0;
        case (opcode)
            OP_R:    range_bad = 1'b0;
            OP_B:    range_bad = !fits13 || imm[0];
            default: range_bad = !fits12;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            imm_err_q <= 1'b0;
        end else if (start) begin
            imm_err_q <= 1'b0;
        end else if (hs && range_bad) begin
            imm_err_q <= 1'b1;
        end
    end

    assign imm_err = imm_err_q;
`else
    logic unused_imm_bits;
    assign unused_imm_bits = ^{imm[N-1:13], imm[0]};
    assign imm_err         = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) state_nxt = LOAD;
            end
            LOAD: begin
                if (start) begin
                    state_nxt = LOAD;
                end else if (((finish || finish_pend) && drained) || last_wr) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (start) state_nxt = LOAD;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            next_addr   <= BASE;
            addr_full   <= 1'b0;
            finish_pend <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            word_cnt    <= '0;
        end else if (start) begin
            // Restart drops whatever is pending and rewinds the address.
            next_addr   <= BASE;
            addr_full   <= 1'b0;
            finish_pend <= 1'b0;
            mem_we      <= 1'b0;
            word_cnt    <= '0;
        end else begin
            finish_pend <= (state == LOAD) && (finish || finish_pend) && !drained;
            if (wr_acc) begin
                word_cnt <= word_cnt + (ADDR_W + 1)'(1);
            end
            if (hs) begin
                mem_we    <= 1'b1;
                mem_addr  <= next_addr;
                mem_wdata <= enc_word;
                next_addr <= next_addr + ADDR_W'(1);
                if (next_addr == LAST_ADDR) begin
                    addr_full <= 1'b1;
                end
            end else if (wr_acc) begin
                mem_we <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_instruction_encoder.sv
// tb/tb_instruction_encoder.sv - self-checking bench for instruction_encoder
module tb_instruction_encoder;

`ifdef ENC_RANGE_CHECK_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n = 1'b0;
    logic        start = 1'b0, finish = 1'b0, in_valid = 1'b0, mem_ready = 1'b0;
    logic [6:0]  opcode = '0, funct7 = '0;
    logic [4:0]  rd = '0, rs1 = '0, rs2 = '0;
    logic [2:0]  funct3 = '0;
    logic [31:0] imm = '0;
    logic        in_ready, mem_we, done, imm_err;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [8:0]  word_cnt;

    logic        s_start = 1'b0, s_finish = 1'b0, s_in_valid = 1'b0, s_mem_ready = 1'b0;
    logic        s_in_ready, s_mem_we, s_done, s_imm_err;
    logic [1:0]  s_mem_addr;
    logic [31:0] s_mem_wdata;
    logic [2:0]  s_word_cnt;

    instruction_encoder #(.N(32), .ADDR_W(8), .BASE_ADDR(0)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .finish(finish),
        .in_valid(in_valid), .in_ready(in_ready), .opcode(opcode), .rd(rd),
        .rs1(rs1), .rs2(rs2), .funct3(funct3), .funct7(funct7), .imm(imm),
        .mem_we(mem_we), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .done(done), .imm_err(imm_err), .word_cnt(word_cnt)
    );

    instruction_encoder #(.N(32), .ADDR_W(2), .BASE_ADDR(0)) u_small (
        .clk(clk), .rst_n(rst_n), .start(s_start), .finish(s_finish),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .opcode(opcode), .rd(rd),
        .rs1(rs1), .rs2(rs2), .funct3(funct3), .funct7(funct7), .imm(imm),
        .mem_we(s_mem_we), .mem_ready(s_mem_ready), .mem_addr(s_mem_addr),
        .mem_wdata(s_mem_wdata), .done(s_done), .imm_err(s_imm_err), .word_cnt(s_word_cnt)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference encoder built from field positions with plain shifts and masks.
    function automatic logic [31:0] ref_word(input logic [6:0] op, input logic [4:0] d,
                                             input logic [4:0] s1, input logic [4:0] s2,
                                             input logic [2:0] f3, input logic [6:0] f7,
                                             input logic [31:0] u);
        logic [31:0] w;
        w = 32'(op) | (32'(f3) << 12) | (32'(s1) << 15);
        if (op == 7'h33)
            w = w | (32'(d) << 7) | (32'(s2) << 20) | (32'(f7) << 25);
        else if (op == 7'h23)
            w = w | ((u & 32'h1F) << 7) | (32'(s2) << 20) | (((u >> 5) & 32'h7F) << 25);
        else if (op == 7'h63)
            w = w | (((u >> 11) & 32'h1) << 7) | (((u >> 1) & 32'hF) << 8) | (32'(s2) << 20)
                  | (((u >> 5) & 32'h3F) << 25) | (((u >> 12) & 32'h1) << 31);
        else
            w = w | (32'(d) << 7) | ((u & 32'hFFF) << 20);
        return w;
    endfunction

    function automatic bit ref_bad(input logic [6:0] op, input logic [31:0] u);
        int v;
        v = signed'(u);
        if (!RC || op == 7'h33) return 1'b0;
        if (op == 7'h63) return (v < -4096) || (v > 4095) || (v % 2 != 0);
        return (v < -2048) || (v > 2047);
    endfunction

    // Scoreboard monitor on the main instance.
    typedef struct packed {
        logic [7:0]  a;
        logic [31:0] d;
    } wr_t;

    wr_t         q[$];
    wr_t         e;
    logic [7:0]  m_addr = '0;
    bit          m_err = 1'b0;
    int          m_cnt = 0;
    bit          mon_en = 1'b0;
    bit          p_stall = 1'b0, p_hs = 1'b0;
    logic [7:0]  p_a = '0;
    logic [31:0] p_d = '0;

    always @(negedge clk) begin
        if (mon_en) begin
            if (!rst_n) begin
                q.delete();
                m_addr = '0; m_err = 1'b0; m_cnt = 0; p_stall = 1'b0; p_hs = 1'b0;
            end else begin
                check("mon_imm_err", 64'(imm_err), 64'(m_err));
                check("mon_word_cnt", 64'(word_cnt), 64'(m_cnt));
                if (p_hs) check("mon_latency", 64'(mem_we), 64'd1);
                if (p_stall) check("mon_stall_hold", 64'({mem_we, mem_addr, mem_wdata}), 64'({1'b1, p_a, p_d}));
                if (mem_we && mem_ready) begin
                    if (q.size() == 0) begin
                        check("mon_unexpected_write", 64'd1, 64'd0);
                    end else begin
                        e = q.pop_front();
                        check("mon_wr_addr", 64'(mem_addr), 64'(e.a));
                        check("mon_wr_data", 64'(mem_wdata), 64'(e.d));
                    end
                    m_cnt++;
                end
                p_stall = mem_we && !mem_ready;
                p_a = mem_addr;
                p_d = mem_wdata;
                p_hs = in_valid && in_ready;
                if (start) begin
                    q.delete();
                    m_addr = '0; m_err = 1'b0; m_cnt = 0; p_stall = 1'b0; p_hs = 1'b0;
                end else if (in_valid && in_ready) begin
                    q.push_back({m_addr, ref_word(opcode, rd, rs1, rs2, funct3, funct7, imm)});
                    m_addr++;
                    if (ref_bad(opcode, imm)) m_err = 1'b1;
                end
            end
        end
    end

    typedef struct packed {
        logic [6:0]  op;
        logic [4:0]  d;
        logic [4:0]  s1;
        logic [4:0]  s2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] im;
        logic [31:0] w;
        logic        err;
    } vec_t;

    vec_t vt[12];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bundle(input logic [6:0] op, input logic [4:0] d, input logic [4:0] s1,
                          input logic [4:0] s2, input logic [2:0] f3, input logic [6:0] f7,
                          input logic [31:0] im);
        opcode = op; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; funct7 = f7; imm = im;
        in_valid = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int acc, wcnt, waited;

    initial begin
        vt[0]  = '{7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd5,        32'h00500093, 1'b0};
        vt[1]  = '{7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'h00, 32'd8,        32'h0020A423, 1'b0};
        vt[2]  = '{7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'h00, 32'hFFFFFFFC, 32'hFE208EE3, 1'b0};
        vt[3]  = '{7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 32'd0,        32'h002081B3, 1'b0};
        vt[4]  = '{7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd2048,     32'h80000093, 1'b1};
        vt[5]  = '{7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFFF800, 32'h80000093, 1'b0};
        vt[6]  = '{7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'h00, 32'h00000FFE, 32'h7E208FE3, 1'b0};
        vt[7]  = '{7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'h00, 32'd3,        32'h00208163, 1'b1};
        vt[8]  = '{7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'h00, 32'hFFFFF7FF, 32'h7E20AFA3, 1'b1};
        vt[9]  = '{7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'h12345678, 32'h402081B3, 1'b0};
        vt[10] = '{7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'h00, 32'hFFFFF000, 32'h80208063, 1'b0};
        vt[11] = '{7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'h00, 32'h00001000, 32'h80208063, 1'b1};

        // Reset state
        rst_n = 1'b0;
        step(); step();
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_mem_we", 64'(mem_we), 64'd0);
        check("rst_mem_addr", 64'(mem_addr), 64'd0);
        check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_imm_err", 64'(imm_err), 64'd0);
        check("rst_word_cnt", 64'(word_cnt), 64'd0);
        step();
        rst_n = 1'b1;
        mon_en = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        check("idle_in_ready", 64'(in_ready), 64'd0);
        step();
        in_valid = 1'b0;

        // Table of single-word encodings, each in a fresh session
        mem_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            start = 1'b1; step(); start = 1'b0;
            bundle(vt[i].op, vt[i].d, vt[i].s1, vt[i].s2, vt[i].f3, vt[i].f7, vt[i].im);
            step();
            in_valid = 1'b0;
            @(negedge clk);
            check($sformatf("vec%0d_we", i), 64'(mem_we), 64'd1);
            check($sformatf("vec%0d_addr", i), 64'(mem_addr), 64'd0);
            check($sformatf("vec%0d_data", i), 64'(mem_wdata), 64'(vt[i].w));
            check($sformatf("vec%0d_imm_err", i), 64'(imm_err), 64'(RC && vt[i].err));
            step();
        end

        // imm_err cleared by start
        start = 1'b1; step(); start = 1'b0;
        bundle(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd2048);
        step(); in_valid = 1'b0;
        @(negedge clk);
        check("err_set", 64'(imm_err), 64'(RC));
        check("err_word", 64'(mem_wdata), 64'h80000093);
        step();
        start = 1'b1; step(); start = 1'b0;
        @(negedge clk);
        check("err_cleared", 64'(imm_err), 64'd0);
        step();

        // Back-to-back S then B
        bundle(vt[1].op, vt[1].d, vt[1].s1, vt[1].s2, vt[1].f3, vt[1].f7, vt[1].im);
        step();
        bundle(vt[2].op, vt[2].d, vt[2].s1, vt[2].s2, vt[2].f3, vt[2].f7, vt[2].im);
        @(negedge clk);
        check("b2b_w0", 64'({mem_we, mem_addr, mem_wdata}), 64'({1'b1, 8'd0, 32'h0020A423}));
        check("b2b_ready", 64'(in_ready), 64'd1);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        check("b2b_w1", 64'({mem_we, mem_addr, mem_wdata}), 64'({1'b1, 8'd1, 32'hFE208EE3}));
        step();

        // Stalled R write
        start = 1'b1; step(); start = 1'b0;
        mem_ready = 1'b0;
        bundle(7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 32'd0);
        step();
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("stall_data", 64'({mem_we, mem_wdata}), 64'({1'b1, 32'h002081B3}));
            check("stall_in_ready", 64'(in_ready), 64'd0);
            step();
        end
        mem_ready = 1'b1;
        @(negedge clk);
        check("stall_data4", 64'({mem_we, mem_wdata}), 64'({1'b1, 32'h002081B3}));
        step();
        @(negedge clk);
        check("stall_word_cnt", 64'(word_cnt), 64'd1);
        check("stall_we_low", 64'(mem_we), 64'd0);
        step();

        // finish while stalled
        start = 1'b1; step(); start = 1'b0;
        mem_ready = 1'b0;
        bundle(7'h13, 5'd2, 5'd3, 5'd0, 3'd0, 7'h00, 32'd7);
        step();
        in_valid = 1'b0;
        finish = 1'b1;
        @(negedge clk);
        check("fin_in_ready", 64'(in_ready), 64'd0);
        step();
        finish = 1'b0;
        @(negedge clk);
        check("fin_stall_done", 64'(done), 64'd0);
        check("fin_stall_we", 64'(mem_we), 64'd1);
        step();
        mem_ready = 1'b1;
        @(negedge clk);
        check("fin_drain_done", 64'(done), 64'd0);
        step();
        @(negedge clk);
        check("fin_done", 64'(done), 64'd1);
        check("fin_done_in_ready", 64'(in_ready), 64'd0);
        check("fin_done_we", 64'(mem_we), 64'd0);
        step();

        // start and finish together
        start = 1'b1; step(); start = 1'b0;
        bundle(7'h13, 5'd1, 5'd1, 5'd0, 3'd0, 7'h00, 32'd1);
        step(); step();
        in_valid = 1'b0;
        step();
        start = 1'b1; finish = 1'b1;
        step();
        start = 1'b0; finish = 1'b0;
        @(negedge clk);
        check("sf_done", 64'(done), 64'd0);
        check("sf_in_ready", 64'(in_ready), 64'd1);
        bundle(7'h13, 5'd4, 5'd0, 5'd0, 3'd0, 7'h00, 32'd9);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        check("sf_addr", 64'({mem_we, mem_addr}), 64'({1'b1, 8'd0}));
        step();

        // Reset mid-session drops the pending write
        start = 1'b1; step(); start = 1'b0;
        mem_ready = 1'b0;
        bundle(7'h13, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 32'd3);
        step();
        in_valid = 1'b0;
        step();
        rst_n = 1'b0;
        step();
        @(negedge clk);
        check("mid_rst_we", 64'(mem_we), 64'd0);
        check("mid_rst_cnt", 64'(word_cnt), 64'd0);
        check("mid_rst_done", 64'(done), 64'd0);
        check("mid_rst_addr", 64'(mem_addr), 64'd0);
        rst_n = 1'b1;
        step();

        // Address-space exhaustion on the 2-bit instance
        s_start = 1'b1; step(); s_start = 1'b0;
        opcode = 7'h13; rd = 5'd1; rs1 = 5'd2; rs2 = 5'd0; funct3 = 3'd1; funct7 = 7'h00; imm = 32'd100;
        s_in_valid = 1'b1; s_mem_ready = 1'b1;
        acc = 0; wcnt = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (s_in_valid && s_in_ready) acc++;
            if (s_mem_we && s_mem_ready) begin
                check("small_addr", 64'(s_mem_addr), 64'(wcnt));
                check("small_data", 64'(s_mem_wdata), 64'(ref_word(7'h13, 5'd1, 5'd2, 5'd0, 3'd1, 7'h00, 32'd100)));
                wcnt++;
            end
            step();
        end
        @(negedge clk);
        check("small_accepts", 64'(acc), 64'd4);
        check("small_writes", 64'(wcnt), 64'd4);
        check("small_done", 64'(s_done), 64'd1);
        check("small_in_ready", 64'(s_in_ready), 64'd0);
        check("small_word_cnt", 64'(s_word_cnt), 64'd4);
        check("small_imm_err", 64'(s_imm_err), 64'd0);
        step();
        s_in_valid = 1'b0;

        // Randomized traffic against the scoreboard
        start = 1'b1; step(); start = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            mem_ready = ($urandom_range(3) != 0);
            start = 1'b0;
            finish = 1'b0;
            if (done) begin
                if ($urandom_range(1) == 0) start = 1'b1;
            end else if ($urandom_range(40) == 0) begin
                finish = 1'b1;
            end else if ($urandom_range(80) == 0) begin
                start = 1'b1;
            end
            case ($urandom_range(4))
                0: opcode = 7'h33;
                1: opcode = 7'h23;
                2: opcode = 7'h63;
                default: opcode = 7'($urandom);
            endcase
            rd = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
            funct3 = 3'($urandom); funct7 = 7'($urandom);
            case ($urandom_range(2))
                0: imm = $urandom_range(4095) - 32'd2048;
                1: imm = $urandom_range(10000) - 32'd5000;
                default: imm = $urandom;
            endcase
            in_valid = !start && ($urandom_range(2) != 0);
            step();
        end
        in_valid = 1'b0; start = 1'b0; mem_ready = 1'b1;
        finish = !done;
        step();
        finish = 1'b0;
        waited = 0;
        while (!done && waited < 40) begin
            step();
            waited++;
        end
        @(negedge clk);
        check("rand_reached_done", 64'(done), 64'd1);
        check("rand_queue_empty", 64'(q.size()), 64'd0);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
